// File: rtl/paralelo_serial_tx_pkg.sv
// Shared constants and types for the parallel-to-serial transmitter.
//   COMMA / IDLE : control words sent during preamble / when no data is valid
//   N_COMMA      : number of commas in the link-up preamble
//   WORD_W       : parallel word width; CNT_W is the bit counter width
//   state_t      : link FSM states
package paralelo_serial_tx_pkg;

  localparam int unsigned WORD_W  = 8;
  localparam int unsigned CNT_W   = $clog2(WORD_W);
  localparam int unsigned N_COMMA = 4;

  localparam logic [WORD_W-1:0] COMMA = 8'hBC;
  localparam logic [WORD_W-1:0] IDLE  = 8'h7C;

  typedef enum logic {
    INIT,
    ACTIVE
  } state_t;

endpackage

// File: rtl/paralelo_serial_tx_shift8.sv
// 8-bit MSB-first shift register with its bit counter.
//   clk_32f  : serial bit clock
//   reset_L  : asynchronous active-low reset
//   load     : load word and restart the counter on this edge
//   word     : parallel word to load
//   serial   : current serial bit (shift register MSB)
//   bit_cnt  : index of the bit currently on serial (0 = bit 7 of the word)
module serial_shift8
  import paralelo_serial_tx_pkg::*;
(
  input  logic              clk_32f,
  input  logic              reset_L,
  input  logic              load,
  input  logic [WORD_W-1:0] word,
  output logic              serial,
  output logic [CNT_W-1:0]  bit_cnt
);

  logic [WORD_W-1:0] shift_q;
  logic [CNT_W-1:0]  cnt_q;

  // Counter resets to the last bit index so the first edge after release is a load edge.
  always_ff @(posedge clk_32f or negedge reset_L) begin
    if (!reset_L) begin
      shift_q <= '0;
      cnt_q   <= CNT_W'(WORD_W - 1);
    end else if (load) begin
      shift_q <= word;
      cnt_q   <= '0;
    end else begin
      shift_q <= {shift_q[WORD_W-2:0], 1'b0};
      cnt_q   <= cnt_q + CNT_W'(1);
    end
  end

  assign serial  = shift_q[WORD_W-1];
  assign bit_cnt = cnt_q;

endmodule

// File: rtl/paralelo_serial_tx.sv
// Parallel-to-serial link transmitter. After reset it sends a preamble of N_COMMA
// comma words, then enters ACTIVE and sends data_in when valid_in is set, IDLE otherwise.
//   clk_32f    : serial bit clock (8x word rate)
//   reset_L    : asynchronous active-low reset
//   data_in    : parallel word from upstream, sampled on load edges only
//   valid_in   : word qualifier, sampled on load edges only
//   data_out   : serial line, MSB first
//   word_start : high while bit 7 of a word is on data_out
//   active_out : high once the preamble is committed (state ACTIVE)
module paralelo_serial_tx
  import paralelo_serial_tx_pkg::*;
(
  input  logic              clk_32f,
  input  logic              reset_L,
  input  logic [WORD_W-1:0] data_in,
  input  logic              valid_in,
  output logic              data_out,
  output logic              word_start,
  output logic              active_out
);

  logic [CNT_W-1:0]  bit_cnt;
  logic              load;
  logic [WORD_W-1:0] next_word;

  state_t     state_q, state_d;
  logic [1:0] comma_cnt_q, comma_cnt_d;

  assign load = (bit_cnt == CNT_W'(WORD_W - 1));

  serial_shift8 u_shift (
    .clk_32f (clk_32f),
    .reset_L (reset_L),
    .load    (load),
    .word    (next_word),
    .serial  (data_out),
    .bit_cnt (bit_cnt)
  );

  always_ff @(posedge clk_32f or negedge reset_L) begin
    if (!reset_L) begin
      state_q     <= INIT;
      comma_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      comma_cnt_q <= comma_cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    comma_cnt_d = comma_cnt_q;
    next_word   = COMMA;
    unique case (state_q)
      INIT: begin
        // The last comma is loaded on the same edge that commits to ACTIVE.
        if (load) begin
          comma_cnt_d = comma_cnt_q + 2'd1;
          if (comma_cnt_q == 2'(N_COMMA - 1)) begin
            state_d = ACTIVE;
          end
        end
      end
      ACTIVE: begin
        next_word = valid_in ? data_in : IDLE;
      end
    endcase
  end

  assign word_start = (bit_cnt == '0);
  assign active_out = (state_q == ACTIVE);

endmodule

// File: tb/tb_paralelo_serial_tx.sv
// Self-checking bench for paralelo_serial_tx. The reference model counts edges since
// reset release: words start every 8 edges from edge 1, the first four are commas,
// later ones are the inputs sampled at the word's first edge (IDLE if not valid).
module tb_paralelo_serial_tx;

  logic       clk_32f = 1'b0;
  logic       reset_L;
  logic [7:0] data_in;
  logic       valid_in;
  logic       data_out;
  logic       word_start;
  logic       active_out;

  paralelo_serial_tx dut (
    .clk_32f    (clk_32f),
    .reset_L    (reset_L),
    .data_in    (data_in),
    .valid_in   (valid_in),
    .data_out   (data_out),
    .word_start (word_start),
    .active_out (active_out)
  );

  always #5 clk_32f = ~clk_32f;

  int errors = 0;
  int checks = 0;
  int e = 0;                 // rising edges since reset release
  logic [7:0] cur_word = '0; // word the model expects on the line

  typedef struct {
    logic       v;
    logic [7:0] d;
    logic [7:0] exp;
  } vec_t;

  vec_t tbl[11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, e);
    end
  endtask

  task automatic tick();
    int pos;
    @(posedge clk_32f);
    e++;
    pos = (e - 1) % 8;
    if (pos == 0) begin
      if (e <= 25) cur_word = 8'hBC;
      else cur_word = valid_in ? data_in : 8'h7C;
    end
    @(negedge clk_32f);
    check("data_out", {31'd0, data_out}, {31'd0, cur_word[7-pos]});
    check("word_start", {31'd0, word_start}, {31'd0, pos == 0});
    check("active_out", {31'd0, active_out}, {31'd0, e >= 25});
  endtask

  // Runs one full word aligned to a load edge and compares the assembled byte.
  task automatic run_word(input string name, input logic [7:0] exp);
    logic [7:0] obs;
    obs = '0;
    for (int i = 0; i < 8; i++) begin
      tick();
      obs = {obs[6:0], data_out};
    end
    check(name, {24'd0, obs}, {24'd0, exp});
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, "_data_out"}, {31'd0, data_out}, 32'd0);
    check({name, "_word_start"}, {31'd0, word_start}, 32'd0);
    check({name, "_active_out"}, {31'd0, active_out}, 32'd0);
  endtask

  // Asserts reset mid-cycle, checks immediate effect, releases on a falling edge.
  task automatic pulse_reset(input string name);
    #2 reset_L = 1'b0;
    #1 check_reset_outputs(name);
    @(negedge clk_32f);
    @(negedge clk_32f);
    reset_L = 1'b1;
    e = 0;
    #1 check_reset_outputs({name, "_rel"});
  endtask

  task automatic preamble();
    for (int i = 0; i < 4; i++) run_word("comma", 8'hBC);
  endtask

  initial begin
    tbl[0]  = '{v: 1'b1, d: 8'hFF, exp: 8'hFF};
    tbl[1]  = '{v: 1'b1, d: 8'h00, exp: 8'h00};
    tbl[2]  = '{v: 1'b0, d: 8'hFF, exp: 8'h7C};
    tbl[3]  = '{v: 1'b1, d: 8'hFF, exp: 8'hFF};
    tbl[4]  = '{v: 1'b1, d: 8'h00, exp: 8'h00};
    tbl[5]  = '{v: 1'b0, d: 8'h00, exp: 8'h7C};
    tbl[6]  = '{v: 1'b1, d: 8'hFF, exp: 8'hFF};
    tbl[7]  = '{v: 1'b1, d: 8'h00, exp: 8'h00};
    tbl[8]  = '{v: 1'b0, d: 8'hA5, exp: 8'h7C};
    tbl[9]  = '{v: 1'b1, d: 8'hBC, exp: 8'hBC};
    tbl[10] = '{v: 1'b1, d: 8'h7C, exp: 8'h7C};

    reset_L  = 1'b0;
    valid_in = 1'b0;
    data_in  = 8'h00;
    @(negedge clk_32f);
    check_reset_outputs("por");
    @(negedge clk_32f);
    reset_L = 1'b1;
    e = 0;
    #1 check_reset_outputs("por_rel");

    // Idle link: four commas then IDLE.
    preamble();
    run_word("idle", 8'h7C);

    // Data at edge 33, inputs changed mid-word before edge 36.
    pulse_reset("rst_a");
    preamble();
    valid_in = 1'b1;
    data_in  = 8'hA5;
    begin
      logic [7:0] obs;
      obs = '0;
      for (int i = 0; i < 8; i++) begin
        if (i == 3) data_in = 8'h3C;
        tick();
        obs = {obs[6:0], data_out};
      end
      check("word_a5", {24'd0, obs}, 32'hA5);
    end
    run_word("word_3c", 8'h3C);

    // Reset mid-preamble between edges 20 and 21.
    pulse_reset("rst_b");
    valid_in = 1'b1;
    data_in  = 8'h55;
    for (int i = 0; i < 20; i++) tick();
    pulse_reset("rst_mid");
    preamble();
    run_word("after_rst", 8'h55);

    // Table: FF/00/IDLE pattern and control words sent verbatim.
    for (int i = 0; i < 11; i++) begin
      valid_in = tbl[i].v;
      data_in  = tbl[i].d;
      run_word($sformatf("tbl%0d", i), tbl[i].exp);
    end

    // Random words with random mid-word input changes that must be ignored.
    for (int w = 0; w < 40; w++) begin
      for (int b = 0; b < 8; b++) begin
        if (b == 0 || ($urandom % 3) == 0) begin
          valid_in = 1'($urandom);
          data_in  = 8'($urandom);
        end
        tick();
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/paralelo_serial_tx.md
PARALELO_SERIAL_TX -- requirements
Module: paralelo_serial_tx

Interface
REQ-001 The module SHALL have exactly one clock and one reset; the reset SHALL be asynchronous and active-low.
REQ-002 Port: clk_32f  input  1  serial bit clock, 8x the word rate; all state SHALL update on its rising edge.
REQ-003 Port: reset_L  input  1  asynchronous active-low reset.
REQ-004 Port: data_in  input  8  parallel word from the upstream L2 mux (data_out_L2).
REQ-005 Port: valid_in  input  1  word-valid qualifier from the upstream L2 mux (valid_bit_L2).
REQ-006 Port: data_out  output  1  serial line, MSB first.
REQ-007 Port: word_start  output  1  high during the cycle in which bit 7 of a word is on data_out.
REQ-008 Port: active_out  output  1  high once the comma preamble has been committed, i.e. the link is in ACTIVE.

Function
REQ-009 Internal state SHALL be shift_reg[7:0], bit_cnt[2:0], fsm state {INIT, ACTIVE} and comma_cnt[1:0].
REQ-010 data_out SHALL equal shift_reg[7], combinationally.
REQ-011 word_start SHALL equal (bit_cnt == 0), combinationally.
REQ-012 active_out SHALL equal (state == ACTIVE).
REQ-013 Load edge = rising edge with bit_cnt == 7: shift_reg <= next_word and bit_cnt <= 0.
REQ-014 Every other edge: shift_reg <= {shift_reg[6:0], 1'b0} and bit_cnt <= bit_cnt + 1.
REQ-015 Load edges SHALL therefore occur at edges 1, 9, 17, ... after reset release.
REQ-016 A loaded word SHALL be on data_out for exactly 8 cycles, bit 7 first.
REQ-017 data_in and valid_in SHALL be sampled only on load edges and ignored at all other times.
REQ-018 Upstream SHALL hold data_in and valid_in stable across each load edge.
REQ-019 INIT: next_word = COMMA (0xBC) regardless of inputs, and comma_cnt increments on each load edge.
REQ-020 INIT: on the load edge with comma_cnt == 3, the FSM SHALL load the 4th COMMA and go to ACTIVE.
REQ-021 As a result, exactly N_COMMA = 4 commas are sent, loaded at edges 1, 9, 17 and 25.
REQ-022 active_out SHALL rise on edge 25, while the 4th comma is still being shifted out.
REQ-023 ACTIVE: next_word = data_in if valid_in = 1, else IDLE (0x7C).
REQ-024 The first input sample SHALL be taken at edge 33.
REQ-025 ACTIVE SHALL persist until reset; a valid_in drop SHALL never return the FSM to INIT.
REQ-026 Latency: a word sampled at load edge k SHALL have bit 7 on data_out in the cycle after edge k and bit 0 in the cycle after edge k+7.
REQ-027 A valid_in toggle between load edges SHALL have no effect.
REQ-028 data_in = 0xBC or 0x7C with valid_in = 1 SHALL be sent verbatim; no escaping is performed.

Reset
REQ-029 While reset_L = 0: shift_reg = 0x00, bit_cnt = 7, state = INIT, comma_cnt = 0.
REQ-030 Resulting output values during reset: data_out = 0, word_start = 0, active_out = 0.
REQ-031 An assertion mid-word or mid-preamble SHALL take effect immediately, without waiting for a clock edge.
REQ-032 After release, a full 4-comma preamble SHALL restart at edge 1.

Structure
REQ-033 A shared package SHALL hold COMMA = 8'hBC, IDLE = 8'h7C, N_COMMA = 4, WORD_W = 8 and the state enum {INIT, ACTIVE}.
REQ-034 The shift register plus bit counter SHALL be one sub-module, serial_shift8.
REQ-035 serial_shift8 SHALL have a load port, a word input, a serial output and a bit_cnt output; the FSM and next_word mux SHALL remain in paralelo_serial_tx.

Verification
REQ-036 The bench SHALL cover: release reset, valid_in = 0 for 40 cycles -> 32 bits 10111100 x4 from edge 1, active_out rising at edge 25, then 01111100 from edge 33.
REQ-037 The bench SHALL cover: after preamble, valid_in = 1 with data_in = 0xA5 held across edge 33 -> data_out 1,0,1,0,0,1,0,1 in cycles after edges 33..40, word_start high only in the cycle after edge 33.
REQ-038 The bench SHALL cover: valid_in and data_in changed to 0x3C at edge 36 (mid-word) -> word from edge 33 unaffected, and 0x3C sent from edge 41.
REQ-039 The bench SHALL cover: reset_L pulsed low between edges 20 and 21 -> data_out, active_out and word_start drop to 0 immediately, and after release 4 fresh commas are sent before any data.
REQ-040 The bench SHALL cover: alternating valid words 0xFF and 0x00 with valid_in = 0 on every third word -> stream FF, 00, 7C repeating, active_out constant 1.
REQ-041 The bench SHALL cover: valid_in = 1 with data_in = 0xBC in ACTIVE -> 0xBC transmitted and the FSM stays in ACTIVE.
